// File: rtl/cronometru_pkg.sv
// Shared types and constants for the BCD lap stopwatch.
package cronometru_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX_UNIT = 4'd9;
   localparam bcd_digit_t SEC_MAX_TENS = 4'd5;

   typedef struct packed {
      logic [7:0] min;
      logic [7:0] sec;
   } bcd_time_t;

   function automatic bcd_digit_t sat_digit(input bcd_digit_t d, input bcd_digit_t lim);
      return (d > lim) ? lim : d;
   endfunction

endpackage

// File: rtl/cronometru_lap_fifo.sv
// First-word-fall-through lap store; head reads as zero while empty.
module cronometru_lap_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         wr_i,
   input  logic         rd_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         valid_o,
   output logic         full_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          empty, do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign valid_o = !empty;
   assign dout_o  = empty ? '0 : mem_q[rptr_q];

   // A full FIFO still accepts a push when the same cycle frees a slot.
   assign do_pop  = rd_i && !empty;
   assign do_push = wr_i && (!full_o || do_pop);

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= din_i;
   end

endmodule

// File: rtl/cronometru_lap.sv
// BCD mm:ss stopwatch with up/down count, preset load and a lap FIFO.
module cronometru_lap
   import cronometru_pkg::*;
#(
   parameter int TICK_DIV  = 1,
   parameter int LAP_DEPTH = 4,
   parameter int MIN_MAX   = 59
) (
   input  logic       clk_out,
   input  logic       reset,
   input  logic       pauza,
   input  logic       mod_jos,
   input  logic       incarca,
   input  logic [7:0] preset_min,
   input  logic [7:0] preset_sec,
   input  logic       lap,
   input  logic       lap_rd,
   output logic [3:0] MIN_BCD1,
   output logic [3:0] MIN_BCD0,
   output logic [3:0] SEC_BCD1,
   output logic [3:0] SEC_BCD0,
   output logic [7:0] lap_min,
   output logic [7:0] lap_sec,
   output logic       lap_valid,
   output logic       lap_full,
   output logic       wrap,
   output logic       gata
);

   localparam int          PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [7:0]  MIN_MAX_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

   logic [PW-1:0] presc_q, presc_d;
   bcd_time_t     time_q, time_d, up_t, dn_t, load_t;
   logic          wrap_q, wrap_d, gata_q, gata_d;
   logic          tick, up_wrap;

   assign tick = !pauza && (presc_q == PRE_LAST);

   // Clamp each preset digit, then clamp the minute pair against MIN_MAX.
   always_comb begin
      load_t.min = {sat_digit(preset_min[7:4], BCD_MAX_UNIT),
                    sat_digit(preset_min[3:0], BCD_MAX_UNIT)};
      if (load_t.min > MIN_MAX_BCD) load_t.min = MIN_MAX_BCD;
      load_t.sec = {sat_digit(preset_sec[7:4], SEC_MAX_TENS),
                    sat_digit(preset_sec[3:0], BCD_MAX_UNIT)};
   end

   always_comb begin
      up_t    = time_q;
      up_wrap = 1'b0;
      if (time_q.sec[3:0] != BCD_MAX_UNIT)      up_t.sec[3:0] = time_q.sec[3:0] + 4'd1;
      else if (time_q.sec[7:4] != SEC_MAX_TENS) up_t.sec = {time_q.sec[7:4] + 4'd1, 4'd0};
      else begin
         up_t.sec = 8'h00;
         if (time_q.min == MIN_MAX_BCD) begin
            up_t.min = 8'h00;
            up_wrap  = 1'b1;
         end else if (time_q.min[3:0] != BCD_MAX_UNIT) up_t.min[3:0] = time_q.min[3:0] + 4'd1;
         else up_t.min = {time_q.min[7:4] + 4'd1, 4'd0};
      end
   end

   // Down count parks at 00:00.
   always_comb begin
      dn_t = time_q;
      if (time_q != '0) begin
         if (time_q.sec[3:0] != 4'd0)      dn_t.sec[3:0] = time_q.sec[3:0] - 4'd1;
         else if (time_q.sec[7:4] != 4'd0) dn_t.sec = {time_q.sec[7:4] - 4'd1, BCD_MAX_UNIT};
         else begin
            dn_t.sec = {SEC_MAX_TENS, BCD_MAX_UNIT};
            if (time_q.min[3:0] != 4'd0) dn_t.min[3:0] = time_q.min[3:0] - 4'd1;
            else dn_t.min = {time_q.min[7:4] - 4'd1, BCD_MAX_UNIT};
         end
      end
   end

   always_comb begin
      presc_d = presc_q;
      time_d  = time_q;
      wrap_d  = 1'b0;
      gata_d  = gata_q;
      if (incarca) begin
         time_d  = load_t;
         presc_d = '0;
         gata_d  = 1'b0;
      end else begin
         if (!pauza)   presc_d = tick ? '0 : presc_q + PW'(1);
         if (!mod_jos) gata_d  = 1'b0;
         if (tick) begin
            if (!mod_jos) begin
               time_d = up_t;
               wrap_d = up_wrap;
            end else begin
               time_d = dn_t;
               if (dn_t == '0) gata_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_out) begin
      if (reset) begin
         presc_q <= '0;
         time_q  <= '0;
         wrap_q  <= 1'b0;
         gata_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         time_q  <= time_d;
         wrap_q  <= wrap_d;
         gata_q  <= gata_d;
      end
   end

   cronometru_lap_fifo #(.DEPTH(LAP_DEPTH), .W(16)) u_fifo (
      .clk_i   (clk_out),
      .rst_i   (reset),
      .wr_i    (lap),
      .rd_i    (lap_rd),
      .din_i   (time_q),
      .dout_o  ({lap_min, lap_sec}),
      .valid_o (lap_valid),
      .full_o  (lap_full)
   );

   assign {MIN_BCD1, MIN_BCD0} = time_q.min;
   assign {SEC_BCD1, SEC_BCD0} = time_q.sec;
   assign wrap = wrap_q;
   assign gata = gata_q;

endmodule
